// File: rtl/serframe_rx.sv
// Serial counter-word receiver: oversamples sclk/sdin/sfrm with clk and rebuilds (WIDTH+1)-bit words.
// Optional even-parity trailer bit when SERFRAME_PARITY_EN is defined.
module serframe_rx #(
    parameter int WIDTH       = 30,
    parameter int TIMEOUT     = 16383,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sclk,
    input  logic           sdin,
    input  logic           sfrm,
    output logic [WIDTH:0] dout,
    output logic           dvalid,
    input  logic           dack,
    output logic           ferr,
    output logic           ovr,
    output logic           busy,
    output logic [1:0]     fsm_state
);

`ifdef SERFRAME_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 2;
`else
    localparam int FRAME_BITS = WIDTH + 1;
`endif
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              rst_pipe;
    logic                    rst_int;
    logic [SYNC_STAGES-1:0]  sclk_q;
    logic [SYNC_STAGES-1:0]  sdin_q;
    logic [SYNC_STAGES-1:0]  sfrm_q;
    logic                    sclk_d;
    logic                    sclk_s;
    logic                    sdin_s;
    logic                    sfrm_s;
    logic                    rise;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   shreg_shift;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_inc;
    logic [TW-1:0]           timer;
    logic                    last_bit;
    logic                    par_err;
    logic                    bad;
    logic [WIDTH:0]          frame_data;

    // Reset asserts asynchronously but releases on a clk edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            sclk_q <= '0;
            sdin_q <= '0;
            sfrm_q <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            sdin_q <= {sdin_q[SYNC_STAGES-2:0], sdin};
            sfrm_q <= {sfrm_q[SYNC_STAGES-2:0], sfrm};
            sclk_d <= sclk_s;
        end
    end

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign sdin_s = sdin_q[SYNC_STAGES-1];
    assign sfrm_s = sfrm_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;

    always_comb begin
        shreg_shift = {shreg[FRAME_BITS-2:0], sdin_s};
        cnt_inc     = cnt + CW'(1);
        last_bit    = rise && (cnt_inc == CW'(FRAME_BITS));
`ifdef SERFRAME_PARITY_EN
        par_err     = ^shreg_shift;
`else
        par_err     = 1'b0;
`endif
        // Data always sits in the top WIDTH+1 bits; a parity trailer lands in bit 0.
        frame_data  = shreg[FRAME_BITS-1 -: WIDTH+1];
    end

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            timer  <= '0;
            bad    <= 1'b0;
            dout   <= '0;
            dvalid <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            ferr <= 1'b0;
            if (dvalid && dack) begin
                dvalid <= 1'b0;
                ovr    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sfrm_s) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        timer <= '0;
                        bad   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (rise) begin
                        shreg <= shreg_shift;
                        cnt   <= cnt_inc;
                        timer <= '0;
                    end else if (timer != TW'(TIMEOUT)) begin
                        timer <= timer + TW'(1);
                    end

                    // A final bit coinciding with the frame fall still counts as complete.
                    if (last_bit) begin
                        state <= WAIT_END;
                        bad   <= par_err;
                        ferr  <= par_err;
                    end else if (!sfrm_s) begin
                        ferr  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!rise && timer == TW'(TIMEOUT - 1)) begin
                        ferr  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                WAIT_END: begin
                    if (rise && !bad) begin
                        ferr <= 1'b1;
                        bad  <= 1'b1;
                    end
                    if (!sfrm_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!bad && !rise) begin
                            if (!dvalid || dack) begin
                                dout   <= frame_data;
                                dvalid <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serframe_rx.sv
// Bench for serframe_rx: directed link scenarios plus random frames checked against a transaction-level model.
module tb_serframe_rx;
    localparam int WIDTH       = 7;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;
`ifdef SERFRAME_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 2;
`else
    localparam int FRAME_BITS = WIDTH + 1;
`endif

    logic           clk;
    logic           reset;
    logic           sclk;
    logic           sdin;
    logic           sfrm;
    logic [WIDTH:0] dout;
    logic           dvalid;
    logic           dack;
    logic           ferr;
    logic           ovr;
    logic           busy;
    logic [1:0]     fsm_state;

    serframe_rx #(
        .WIDTH       (WIDTH),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .sdin      (sdin),
        .sfrm      (sfrm),
        .dout      (dout),
        .dvalid    (dvalid),
        .dack      (dack),
        .ferr      (ferr),
        .ovr       (ovr),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int ferr_seen;
    int dvalid_cycles;
    logic [WIDTH:0] last_dout;

    // monitor: ferr pulses and dvalid cycles, sampled on the falling edge
    always @(negedge clk) begin
        if (ferr === 1'b1) ferr_seen++;
        if (dvalid === 1'b1) begin
            dvalid_cycles++;
            last_dout = dout;
        end
    end

    // scoreboard: words expected to be held on dout, sticky overrun, framing errors
    logic [WIDTH:0] exp_q[$];
    bit             m_ovr;
    int             m_ferr;
    int             ferr_base;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver: sfrm high, nbits sclk periods (20 clk each), then sfrm low
    task automatic send_frame(input logic [WIDTH:0] w, input int nbits, input logic xbit);
        sfrm = 1'b1;
        clk_wait(10);
        for (int i = 0; i < nbits; i++) begin
            if (i <= WIDTH)          sdin = w[WIDTH-i];
            else if (i == WIDTH + 1) sdin = xbit;
            else                     sdin = 1'($urandom_range(0, 1));
            clk_wait(10);
            sclk = 1'b1;
            clk_wait(10);
            sclk = 1'b0;
        end
        clk_wait(5);
        sfrm = 1'b0;
        clk_wait(10);
        sdin = 1'b0;
    endtask

    // reference model: a frame is good only with exactly the right number of bits (and even parity)
    task automatic model_frame(input logic [WIDTH:0] w, input int nbits, input logic xbit);
        bit ok;
        ok = (nbits == FRAME_BITS);
`ifdef SERFRAME_PARITY_EN
        if ((^w ^ xbit) != 1'b0) ok = 1'b0;
`endif
        if (!ok) m_ferr++;
        else if (exp_q.size() == 0) exp_q.push_back(w);
        else m_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, " ferr count"}, ferr_seen - ferr_base, m_ferr);
        check_eq({tag, " dvalid"}, dvalid, (exp_q.size() != 0) ? 1 : 0);
        check_eq({tag, " ovr"}, ovr, m_ovr);
        if (exp_q.size() != 0) check_eq({tag, " dout"}, dout, exp_q[0]);
    endtask

    task automatic frame_and_check(input string tag, input logic [WIDTH:0] w, input int nbits,
                                   input logic xbit);
        send_frame(w, nbits, xbit);
        model_frame(w, nbits, xbit);
        check_state(tag);
    endtask

    task automatic accept_word(input string tag);
        check_state(tag);
        dack = 1'b1;
        clk_wait(1);
        dack = 1'b0;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            m_ovr = 1'b0;
        end
        check_eq({tag, " dvalid after ack"}, dvalid, 0);
        check_eq({tag, " ovr after ack"}, ovr, m_ovr);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dv_base;
        logic [WIDTH:0] w;
        int nb;
        logic xb;

        n_checks  = 0;
        n_errors  = 0;
        ferr_base = 0;
        m_ferr    = 0;
        m_ovr     = 1'b0;
        reset = 1'b0;
        sclk  = 1'b0;
        sdin  = 1'b0;
        sfrm  = 1'b0;
        dack  = 1'b0;

        // reset state
        clk_wait(3);
        check_eq("rst dout", dout, 0);
        check_eq("rst dvalid", dvalid, 0);
        check_eq("rst ferr", ferr, 0);
        check_eq("rst ovr", ovr, 0);
        check_eq("rst busy", busy, 0);
        reset = 1'b1;
        clk_wait(5);
        check_eq("post rst state", fsm_state, 0);
        check_eq("post rst dvalid", dvalid, 0);

        // T1: consumer always ready, word shows for exactly one cycle
        dack    = 1'b1;
        dv_base = dvalid_cycles;
        send_frame(8'hA5, FRAME_BITS, ^8'hA5);
        check_eq("t1 dvalid cycles", dvalid_cycles - dv_base, 1);
        check_eq("t1 dout", last_dout, 8'hA5);
        check_eq("t1 ferr count", ferr_seen - ferr_base, m_ferr);
        check_eq("t1 ovr", ovr, 0);
        check_eq("t1 dvalid", dvalid, 0);
        dack = 1'b0;

        // T2: overrun on the second word, cleared by the accept
        frame_and_check("t2 first", 8'h3C, FRAME_BITS, ^8'h3C);
        frame_and_check("t2 second", 8'hC3, FRAME_BITS, ^8'hC3);
        accept_word("t2 accept");

        // T3: short frame then a good one
        frame_and_check("t3 short", 8'h81, 5, 1'b0);
        frame_and_check("t3 full", 8'h81, FRAME_BITS, ^8'h81);
        accept_word("t3 accept");

        // T4: sclk stalls after 3 bits with the frame still open
        sfrm = 1'b1;
        clk_wait(10);
        for (int i = 0; i < 3; i++) begin
            sdin = 1'($urandom_range(0, 1));
            clk_wait(10);
            sclk = 1'b1;
            if (i < 2) begin
                clk_wait(10);
                sclk = 1'b0;
            end
        end
        lat = 0;
        while (ferr !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 10) sclk = 1'b0;
        end
        m_ferr++;
        check_eq("t4 timeout latency", lat, TIMEOUT + SYNC_STAGES + 1);
        check_eq("t4 busy", busy, 0);
        check_eq("t4 state", fsm_state, 0);
        check_eq("t4 dvalid", dvalid, 0);
        sfrm = 1'b0;
        clk_wait(20);
        // the still-high sfrm reopens a frame that then ends empty; discount that pulse
        ferr_base = ferr_seen - m_ferr;
        check_eq("t4 busy settled", busy, 0);

        // T5: asynchronous reset in the middle of a frame with a word pending
        frame_and_check("t5 pending", 8'h5A, FRAME_BITS, ^8'h5A);
        sfrm = 1'b1;
        clk_wait(10);
        for (int i = 0; i < 4; i++) begin
            sdin = 1'($urandom_range(0, 1));
            clk_wait(10);
            sclk = 1'b1;
            clk_wait(10);
            sclk = 1'b0;
        end
        check_eq("t5 busy mid-frame", busy, 1);
        reset = 1'b0;
        #1;
        check_eq("t5 rst dout", dout, 0);
        check_eq("t5 rst dvalid", dvalid, 0);
        check_eq("t5 rst ferr", ferr, 0);
        check_eq("t5 rst ovr", ovr, 0);
        check_eq("t5 rst busy", busy, 0);
        exp_q.delete();
        m_ovr = 1'b0;
        sfrm  = 1'b0;
        sdin  = 1'b0;
        clk_wait(3);
        reset = 1'b1;
        clk_wait(10);
        frame_and_check("t5 after", 8'hFF, FRAME_BITS, ^8'hFF);
        accept_word("t5 accept");

`ifdef SERFRAME_PARITY_EN
        // T6: parity trailer good and bad
        frame_and_check("t6 good parity", 8'h01, FRAME_BITS, 1'b1);
        accept_word("t6 accept");
        frame_and_check("t6 bad parity", 8'h01, FRAME_BITS, 1'b0);
`endif

        // random frames: mostly good, some short or long, random accept behaviour
        for (int k = 0; k < 30; k++) begin
            w  = (WIDTH + 1)'($urandom);
            nb = $urandom_range(0, 99);
            if (nb < 70)      nb = FRAME_BITS;
            else if (nb < 85) nb = $urandom_range(1, FRAME_BITS - 1);
            else              nb = FRAME_BITS + 1;
            xb = ^w;
`ifdef SERFRAME_PARITY_EN
            if ($urandom_range(0, 9) == 0) xb = ~xb;
`endif
            frame_and_check($sformatf("rnd%0d", k), w, nb, xb);
            if ($urandom_range(0, 1) == 1) accept_word($sformatf("rnd%0d accept", k));
        end
        accept_word("final drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
